spike_event_scheduler: RTL and testbench

Sequencer for one SNN layer's event-driven datapath. Per timestep, accepts a pre-synaptic spike vector, serialises its set bits into one spike address per cycle with `en_accum` (driving per-neuron weight-BRAM reads and membrane accumulation), waits out the neuron pipeline, fires a single `en_activ` pulse for threshold/leak, then repeats for `TIMESTEPS` timesteps. It sits between the spike source and the neuron array.

---
 rtl/snn_sched_pkg.sv | 23 ++
 rtl/spike_prio_enc.sv | 24 ++
 rtl/spike_event_scheduler.sv | 177 +++++++++++++++++
 tb/tb_spike_event_scheduler.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_sched_pkg.sv
// Shared types and defaults for the SNN spike event scheduler.
// States, default pipeline/timestep constants and the counter-width helper.
package snn_sched_pkg;

  localparam int unsigned DEF_NEURON_LAT = 4;
  localparam int unsigned DEF_TIMESTEPS  = 25;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_VEC,
    S_ACCUM,
    S_DRAIN,
    S_ACTIV,
    S_SETTLE,
    S_DONE
  } sched_state_t;

  // Bits needed to hold values 0..max_val inclusive (at least 1).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/spike_prio_enc.sv
// Combinational lowest-set-bit finder over a spike vector.
// idx_c is the index of the lowest set bit; any_c flags a nonzero vector.
module spike_prio_enc #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx_c,
  output logic             any_c
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx_c = '0;
    any_c = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx_c = IDX_W'(i);
        any_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spike_event_scheduler.sv
// Per-timestep sequencer for one SNN layer: serialises spike vectors into addresses,
// waits out the neuron pipeline, pulses activation. Optional SCHED_STATS_EN builds spk_count.
module spike_event_scheduler
  import snn_sched_pkg::*;
#(
  parameter  int unsigned PRE_SYN_SIZE = 64,
  parameter  int unsigned NEURON_LAT   = DEF_NEURON_LAT,
  parameter  int unsigned TIMESTEPS    = DEF_TIMESTEPS,
  parameter  int unsigned ADDR_W       = $clog2(PRE_SYN_SIZE),
  localparam int unsigned TS_W         = cnt_width(TIMESTEPS),
  localparam int unsigned CNT_W        = cnt_width(PRE_SYN_SIZE * TIMESTEPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    spk_valid,
  input  logic [PRE_SYN_SIZE-1:0] spk_vec,
  output logic                    spk_ready,
  output logic [ADDR_W-1:0]       spk_addr,
  output logic                    en_accum,
  output logic                    en_activ,
  output logic [TS_W-1:0]         ts_idx,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        spk_count
);

  localparam int unsigned LAT_W = cnt_width(NEURON_LAT);

  sched_state_t            state_q, state_d;
  logic [PRE_SYN_SIZE-1:0] pending_q, pending_d;
  logic [LAT_W-1:0]        lat_cnt_q, lat_cnt_d;
  logic                    spk_ready_d, en_accum_d, en_activ_d, done_d;
  logic [ADDR_W-1:0]       spk_addr_d;
  logic [TS_W-1:0]         ts_idx_d;

  logic [PRE_SYN_SIZE-1:0] enc_src_c, pending_clr_c;
  logic [ADDR_W-1:0]       enc_idx_c;
  logic                    enc_any_c;
  logic                    lat_last_c;

  // One encoder serves both the incoming-vector zero check and the ACCUM walk.
  assign enc_src_c     = (state_q == S_WAIT_VEC) ? spk_vec : pending_q;
  assign pending_clr_c = enc_src_c & ~(PRE_SYN_SIZE'(1) << enc_idx_c);
  assign lat_last_c    = (lat_cnt_q == LAT_W'(NEURON_LAT - 1));

  spike_prio_enc #(
    .WIDTH (PRE_SYN_SIZE),
    .IDX_W (ADDR_W)
  ) u_prio_enc (
    .vec   (enc_src_c),
    .idx_c (enc_idx_c),
    .any_c (enc_any_c)
  );

  // Next state and next registered outputs; outputs track the state they lead into.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    lat_cnt_d   = lat_cnt_q;
    spk_addr_d  = spk_addr;
    ts_idx_d    = ts_idx;
    spk_ready_d = 1'b0;
    en_accum_d  = 1'b0;
    en_activ_d  = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_WAIT_VEC;
          ts_idx_d    = '0;
          spk_ready_d = 1'b1;
        end
      end
      S_WAIT_VEC: begin
        if (spk_valid && spk_ready) begin
          lat_cnt_d = '0;
          if (enc_any_c) begin
            state_d    = S_ACCUM;
            en_accum_d = 1'b1;
            spk_addr_d = enc_idx_c;
            pending_d  = pending_clr_c;
          end else begin
            state_d   = S_DRAIN;
            pending_d = '0;
          end
        end else begin
          spk_ready_d = 1'b1;
        end
      end
      S_ACCUM: begin
        if (enc_any_c) begin
          en_accum_d = 1'b1;
          spk_addr_d = enc_idx_c;
          pending_d  = pending_clr_c;
        end else begin
          state_d   = S_DRAIN;
          lat_cnt_d = '0;
        end
      end
      S_DRAIN: begin
        if (lat_last_c) begin
          state_d    = S_ACTIV;
          en_activ_d = 1'b1;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      S_ACTIV: begin
        state_d   = S_SETTLE;
        lat_cnt_d = '0;
      end
      S_SETTLE: begin
        if (!lat_last_c) begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end else if (ts_idx == TS_W'(TIMESTEPS - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d     = S_WAIT_VEC;
          ts_idx_d    = ts_idx + TS_W'(1);
          spk_ready_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      lat_cnt_q <= '0;
      spk_ready <= 1'b0;
      spk_addr  <= '0;
      en_accum  <= 1'b0;
      en_activ  <= 1'b0;
      ts_idx    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      lat_cnt_q <= lat_cnt_d;
      spk_ready <= spk_ready_d;
      spk_addr  <= spk_addr_d;
      en_accum  <= en_accum_d;
      en_activ  <= en_activ_d;
      ts_idx    <= ts_idx_d;
      busy      <= (state_d != S_IDLE);
      done      <= done_d;
    end
  end

`ifdef SCHED_STATS_EN
  logic count_clr_c;

  assign count_clr_c = (state_q == S_IDLE) && start;

  // Counts issued addresses; held after DONE until the next accepted start.
  always_ff @(posedge clk) begin
    if (rst || count_clr_c) begin
      spk_count <= '0;
    end else if (en_accum_d) begin
      spk_count <= spk_count + CNT_W'(1);
    end
  end
`else
  assign spk_count = '0;
`endif

endmodule

// File: tb/tb_spike_event_scheduler.sv
// Scoreboard bench for spike_event_scheduler (PRE_SYN_SIZE=8, NEURON_LAT=4, TIMESTEPS=3).
// Driver pushes expected strobes derived from the timing rules; a negedge monitor pops and compares.
module tb_spike_event_scheduler;

  localparam int unsigned N   = 8;
  localparam int unsigned LAT = 4;
  localparam int unsigned TS  = 3;
`ifdef SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int EV_ACCUM = 0;
  localparam int EV_ACTIV = 1;
  localparam int EV_DONE  = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         spk_valid = 1'b0;
  logic [N-1:0] spk_vec = '0;
  logic         spk_ready;
  logic [2:0]   spk_addr;
  logic         en_accum;
  logic         en_activ;
  logic [1:0]   ts_idx;
  logic         busy;
  logic         done;
  logic [4:0]   spk_count;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  bit prev_done = 1'b0;

  typedef struct {
    int kind;
    int addr;
    int ts;
    int at;
    int cnt;
  } ev_t;

  ev_t exp_q[$];

  spike_event_scheduler #(
    .PRE_SYN_SIZE (N),
    .NEURON_LAT   (LAT),
    .TIMESTEPS    (TS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .spk_valid (spk_valid),
    .spk_vec   (spk_vec),
    .spk_ready (spk_ready),
    .spk_addr  (spk_addr),
    .en_accum  (en_accum),
    .en_activ  (en_activ),
    .ts_idx    (ts_idx),
    .busy      (busy),
    .done      (done),
    .spk_count (spk_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int addr, input int ts, input int at, input int cnt);
    ev_t e;
    e.kind = kind; e.addr = addr; e.ts = ts; e.at = at; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
      return;
    end
    e = exp_q.pop_front();
    check("ev_kind", kind, e.kind);
    check("ev_cycle", cyc, e.at);
    check("ev_ts_idx", ts_idx, e.ts);
    if (kind == EV_ACCUM) check("ev_spk_addr", spk_addr, e.addr);
    if (kind == EV_DONE)  check("ev_spk_count", spk_count, e.cnt);
  endtask

  // Monitor: every strobe the DUT presents must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      check("accum_activ_excl", 32'(en_accum & en_activ), 32'd0);
      if (prev_done) check("busy_after_done", busy, 32'd0);
      if (en_accum) pop_check(EV_ACCUM);
      if (en_activ) pop_check(EV_ACTIV);
      if (done)     pop_check(EV_DONE);
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_spk_ready"}, spk_ready, 0);
    check({tag, "_spk_addr"}, spk_addr, 0);
    check({tag, "_en_accum"}, en_accum, 0);
    check({tag, "_en_activ"}, en_activ, 0);
    check({tag, "_ts_idx"}, ts_idx, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_spk_count"}, spk_count, 0);
  endtask

  // Expected strobes for a vector accepted with the handshake present in cycle t.
  task automatic push_timestep(input logic [N-1:0] v, input int ts, input int t,
                               input bit last, input int total);
    int j, k;
    j = 0;
    k = $countones(v);
    for (int b = 0; b < int'(N); b++) begin
      if (v[b]) begin
        push_ev(EV_ACCUM, b, ts, t + 1 + j, 0);
        j++;
      end
    end
    push_ev(EV_ACTIV, 0, ts, t + k + int'(LAT) + 1, 0);
    if (last) push_ev(EV_DONE, 0, ts, t + k + 2 * int'(LAT) + 2, STATS ? total : 0);
  endtask

  task automatic run_inference(input logic [N-1:0] v0, input logic [N-1:0] v1,
                               input logic [N-1:0] v2, input bit noise);
    logic [N-1:0] vecs [TS];
    int exp_ready, t, delay, tmo, total;
    bit seen;
    vecs[0] = v0; vecs[1] = v1; vecs[2] = v2;
    total = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_ready", spk_ready, 1);
    check("start_busy", busy, 1);
    check("start_ts_idx", ts_idx, 0);
    check("start_spk_count", spk_count, 0);
    exp_ready = cyc;
    for (int ts_i = 0; ts_i < int'(TS); ts_i++) begin
      delay = $urandom_range(0, 2);
      seen = 1'b0;
      tmo = 0;
      while (!(spk_ready && delay == 0)) begin
        if (spk_ready) begin
          if (!seen) begin
            check("ready_cycle", cyc, exp_ready);
            seen = 1'b1;
          end
          delay--;
          spk_valid = 1'b0;
          start = 1'b0;
        end else begin
          spk_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
          spk_vec = N'($urandom);
          start = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        tmo++;
        if (tmo > 200) begin
          start = 1'b0;
          spk_valid = 1'b0;
          checks++;
          errors++;
          $display("FAIL ready_timeout: got no spk_ready expected by cycle %0d", exp_ready);
          return;
        end
        @(negedge clk);
      end
      if (!seen) check("ready_cycle", cyc, exp_ready);
      check("accept_ts_idx", ts_idx, ts_i);
      start = 1'b0;
      spk_valid = 1'b1;
      spk_vec = vecs[ts_i];
      t = cyc;
      total += $countones(vecs[ts_i]);
      push_timestep(vecs[ts_i], ts_i, t, ts_i == int'(TS) - 1, total);
      exp_ready = t + $countones(vecs[ts_i]) + 2 * int'(LAT) + 2;
      @(negedge clk);
      check("ready_drop", spk_ready, 0);
      spk_valid = noise;
      spk_vec = N'($urandom);
    end
    start = 1'b0;
    tmo = 0;
    while (exp_q.size() != 0) begin
      tmo++;
      if (tmo > 200) begin
        spk_valid = 1'b0;
        checks++;
        errors++;
        $display("FAIL done_timeout: got %0d pending events expected 0", exp_q.size());
        exp_q.delete();
        return;
      end
      @(negedge clk);
      spk_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    spk_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Reset lands during the second ACCUM cycle of a 5-spike vector.
  task automatic reset_mid_accum();
    logic [N-1:0] v;
    int t;
    v = 8'b0111_0110;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rtest_ready", spk_ready, 1);
    spk_valid = 1'b1;
    spk_vec = v;
    t = cyc;
    push_timestep(v, 0, t, 1'b0, 0);
    @(negedge clk);
    spk_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_rst");
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
  endtask

  function automatic logic [N-1:0] rand_vec();
    return ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    run_inference(8'hFF, 8'h00, 8'h01, 1'b0);
    run_inference(8'hA5, 8'h00, 8'h5A, 1'b0);
    reset_mid_accum();
    run_inference(8'hA5, 8'h00, 8'h5A, 1'b1);
    run_inference(8'h81, 8'h3C, 8'h80, 1'b1);
    repeat (6) run_inference(rand_vec(), rand_vec(), rand_vec(), 1'b1);

    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
